// File: rtl/bp_l15_miss_engine_pkg.sv
// Shared encodings for the BlackParrot D-cache <-> OpenPiton L1.5 miss engine:
// L1.5 request/return codes, PCX sizes, request types and FSM states.
package bp_l15_miss_engine_pkg;

  localparam logic [4:0] LOAD_RQ  = 5'b00000;
  localparam logic [4:0] STORE_RQ = 5'b00001;

  localparam logic [3:0] LOAD_RET  = 4'b0000;
  localparam logic [3:0] EVICT_REQ = 4'b0011;
  localparam logic [3:0] ST_ACK    = 4'b0100;
  localparam logic [3:0] INT_RET   = 4'b0111;

  localparam logic [2:0] PCX_SZ_1B  = 3'b000;
  localparam logic [2:0] PCX_SZ_2B  = 3'b001;
  localparam logic [2:0] PCX_SZ_4B  = 3'b010;
  localparam logic [2:0] PCX_SZ_8B  = 3'b011;
  localparam logic [2:0] PCX_SZ_16B = 3'b111;

  typedef enum logic [1:0] {
    REQ_LOAD  = 2'd0,
    REQ_STORE = 2'd1,
    REQ_UC    = 2'd2,
    REQ_RSVD  = 2'd3
  } req_type_e;

  typedef enum logic [2:0] {
    S_RESET,
    S_READY,
    S_SEND,
    S_WAIT,
    S_FILL,
    S_UC_DONE
  } state_e;

  // D-cache request size is log2(bytes); map onto the PCX size field.
  function automatic logic [2:0] size_to_pcx(input logic [1:0] sz);
    case (sz)
      2'd0:    return PCX_SZ_1B;
      2'd1:    return PCX_SZ_2B;
      2'd2:    return PCX_SZ_4B;
      default: return PCX_SZ_8B;
    endcase
  endfunction

endpackage

// File: rtl/bp_l15_miss_engine_if.sv
// Transducer <-> L1.5 request/return bus. master = miss engine, slave = L1.5.
interface bp_l15_miss_engine_if;
  logic        transducer_l15_val;
  logic [4:0]  transducer_l15_rqtype;
  logic [2:0]  transducer_l15_size;
  logic [39:0] transducer_l15_address;
  logic [63:0] transducer_l15_data;
  logic [1:0]  transducer_l15_l1rplway;
  logic        transducer_l15_nc;
  logic        l15_transducer_ack;

  logic        l15_transducer_val;
  logic [3:0]  l15_transducer_returntype;
  logic [63:0] l15_transducer_data_0;
  logic [63:0] l15_transducer_data_1;
  logic [11:0] l15_transducer_inval_address_15_4;
  logic        transducer_l15_req_ack;

  modport master (
    output transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
           transducer_l15_address, transducer_l15_data, transducer_l15_l1rplway,
           transducer_l15_nc, transducer_l15_req_ack,
    input  l15_transducer_ack, l15_transducer_val, l15_transducer_returntype,
           l15_transducer_data_0, l15_transducer_data_1,
           l15_transducer_inval_address_15_4
  );

  modport slave (
    input  transducer_l15_val, transducer_l15_rqtype, transducer_l15_size,
           transducer_l15_address, transducer_l15_data, transducer_l15_l1rplway,
           transducer_l15_nc, transducer_l15_req_ack,
    output l15_transducer_ack, l15_transducer_val, l15_transducer_returntype,
           l15_transducer_data_0, l15_transducer_data_1,
           l15_transducer_inval_address_15_4
  );
endinterface

// File: rtl/bsg_serial_in_parallel_out_full.sv
// Collects els_p serial words into one parallel word; valid once full, cleared on yumi.
module bsg_serial_in_parallel_out_full #(
  parameter int width_p = 128,
  parameter int els_p   = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       v_i,
  input  logic [width_p-1:0]         data_i,
  input  logic                       yumi_i,
  output logic                       v_o,
  output logic [width_p*els_p-1:0]   data_o
);
  localparam int cnt_w_lp = $clog2(els_p+1);

  logic [els_p-1:0][width_p-1:0] data_r;
  logic [cnt_w_lp-1:0]           cnt_r;

  assign v_o    = (cnt_r == cnt_w_lp'(els_p));
  assign data_o = data_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_r <= '0;
      cnt_r  <= '0;
    end else if (yumi_i) begin
      data_r <= '0;
      cnt_r  <= '0;
    end else if (v_i && !v_o) begin
      for (int i = 0; i < els_p; i++)
        if (cnt_r == cnt_w_lp'(i)) data_r[i] <= data_i;
      cnt_r <= cnt_r + cnt_w_lp'(1);
    end
  end
endmodule

// File: rtl/bp_l15_miss_engine.sv
// Single-outstanding miss/store/uncached engine between the BlackParrot D-cache and
// the OpenPiton L1.5; also turns L1.5 evictions into D-cache invalidates.
module bp_l15_miss_engine
  import bp_l15_miss_engine_pkg::*;
#(
  parameter int paddr_width_p = 40,
  parameter int block_width_p = 512,
  parameter int sets_p        = 64,
  parameter int ways_p        = 8,
  parameter int ptag_width_p  = 28
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  output logic                         ready_o,
  input  logic                         req_v_i,
  input  logic [1:0]                   req_type_i,
  input  logic [paddr_width_p-1:0]     req_addr_i,
  input  logic [$clog2(ways_p)-1:0]    req_way_i,
  input  logic [63:0]                  req_data_i,
  input  logic [1:0]                   req_size_i,
  bp_l15_miss_engine_if.master         l15,
  output logic                         fill_v_o,
  output logic [block_width_p-1:0]     fill_data_o,
  output logic [$clog2(sets_p)-1:0]    fill_index_o,
  output logic [$clog2(ways_p)-1:0]    fill_way_o,
  output logic [ptag_width_p-1:0]      fill_tag_o,
  input  logic                         fill_yumi_i,
  output logic                         uc_v_o,
  output logic [63:0]                  uc_data_o,
  input  logic                         uc_yumi_i,
  output logic                         inval_v_o,
  output logic [$clog2(sets_p)-1:0]    inval_index_o,
  input  logic                         inval_yumi_i
);
  localparam int beats_lp   = block_width_p / 128;
  localparam int beat_w_lp  = $clog2(beats_lp + 1);
  localparam int offset_lp  = $clog2(block_width_p / 8);
  localparam int index_w_lp = $clog2(sets_p);
  localparam int way_w_lp   = $clog2(ways_p);

  state_e                    state_r, state_n;
  req_type_e                 type_r;
  logic [paddr_width_p-1:0]  addr_r, blk_addr;
  logic [way_w_lp-1:0]       way_r;
  logic [63:0]               data_r, uc_data_r;
  logic [1:0]                size_r;
  logic [beat_w_lp-1:0]      beat_r;
  logic                      inval_v_r;
  logic [index_w_lp-1:0]     inval_index_r;
  logic                      ret_v, accept, int_take, evict_take, wait_take;
  logic                      load_take, uc_take, fill_done, sipo_v;
  logic [3:0]                want_ret;
  logic                      unused;

  assign ret_v    = l15.l15_transducer_val;
  assign want_ret = (type_r == REQ_STORE) ? ST_ACK : LOAD_RET;
  assign accept   = ready_o & req_v_i & (req_type_i != REQ_RSVD);
  // Gate with reset so an INT_RET presented while reset is held is not consumed and lost.
  assign int_take   = reset_n_i & (state_r == S_RESET) & ret_v
                    & (l15.l15_transducer_returntype == INT_RET);
  assign evict_take = (state_r != S_RESET) & ret_v & ~inval_v_r
                    & (l15.l15_transducer_returntype == EVICT_REQ);
  assign wait_take  = (state_r == S_WAIT) & ret_v
                    & (l15.l15_transducer_returntype == want_ret);
  assign load_take  = wait_take & (type_r == REQ_LOAD);
  assign uc_take    = wait_take & (type_r == REQ_UC);
  assign fill_done  = fill_v_o & fill_yumi_i;
  assign l15.transducer_l15_req_ack = int_take | evict_take | wait_take;

  assign blk_addr = {addr_r[paddr_width_p-1:offset_lp], {offset_lp{1'b0}}}
                  + (paddr_width_p'(beat_r) << 4);

  assign ready_o       = (state_r == S_READY);
  assign fill_v_o      = (state_r == S_FILL) & sipo_v;
  assign fill_index_o  = fill_v_o ? addr_r[offset_lp +: index_w_lp] : '0;
  assign fill_tag_o    = fill_v_o ? addr_r[paddr_width_p-1 -: ptag_width_p] : '0;
  assign fill_way_o    = fill_v_o ? way_r : '0;
  assign uc_v_o        = (state_r == S_UC_DONE);
  assign uc_data_o     = uc_data_r;
  assign inval_v_o     = inval_v_r;
  assign inval_index_o = inval_index_r;
  assign unused        = ^l15.l15_transducer_inval_address_15_4;

  bsg_serial_in_parallel_out_full #(
    .width_p(128),
    .els_p  (beats_lp)
  ) fill_sipo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .v_i      (load_take),
    .data_i   ({l15.l15_transducer_data_1, l15.l15_transducer_data_0}),
    .yumi_i   (fill_done),
    .v_o      (sipo_v),
    .data_o   (fill_data_o)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= S_RESET;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n                     = state_r;
    l15.transducer_l15_val      = 1'b0;
    l15.transducer_l15_rqtype   = LOAD_RQ;
    l15.transducer_l15_size     = 3'b000;
    l15.transducer_l15_address  = '0;
    l15.transducer_l15_data     = '0;
    l15.transducer_l15_l1rplway = '0;
    l15.transducer_l15_nc       = 1'b0;
    case (state_r)
      S_RESET:   if (int_take) state_n = S_READY;
      S_READY:   if (accept) state_n = S_SEND;
      S_SEND: begin
        l15.transducer_l15_val = 1'b1;
        l15.transducer_l15_nc  = (type_r == REQ_UC);
        case (type_r)
          REQ_LOAD: begin
            l15.transducer_l15_size     = PCX_SZ_16B;
            l15.transducer_l15_address  = 40'(blk_addr);
            l15.transducer_l15_l1rplway = 2'(way_r);
          end
          REQ_STORE: begin
            l15.transducer_l15_rqtype  = STORE_RQ;
            l15.transducer_l15_size    = size_to_pcx(size_r);
            l15.transducer_l15_address = 40'(addr_r);
            l15.transducer_l15_data    = data_r;
          end
          default: begin
            l15.transducer_l15_size    = size_to_pcx(size_r);
            l15.transducer_l15_address = 40'(addr_r);
          end
        endcase
        if (l15.l15_transducer_ack) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (wait_take) begin
          case (type_r)
            REQ_LOAD:  state_n = (beat_r == beat_w_lp'(beats_lp - 1)) ? S_FILL : S_SEND;
            REQ_STORE: state_n = S_READY;
            default:   state_n = S_UC_DONE;
          endcase
        end
      end
      S_FILL:    if (fill_done) state_n = S_READY;
      S_UC_DONE: if (uc_yumi_i) state_n = S_READY;
      default:   state_n = S_RESET;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      type_r        <= REQ_LOAD;
      addr_r        <= '0;
      way_r         <= '0;
      data_r        <= '0;
      size_r        <= '0;
      beat_r        <= '0;
      uc_data_r     <= '0;
      inval_v_r     <= 1'b0;
      inval_index_r <= '0;
    end else begin
      if (accept) begin
        type_r <= req_type_e'(req_type_i);
        addr_r <= req_addr_i;
        way_r  <= req_way_i;
        data_r <= req_data_i;
        size_r <= req_size_i;
      end
      if (load_take && beat_r != beat_w_lp'(beats_lp)) beat_r <= beat_r + beat_w_lp'(1);
      else if (fill_done)                              beat_r <= '0;
      if (uc_take) uc_data_r <= l15.l15_transducer_data_0;
      // inval_address_15_4 carries paddr[15:4]; the set index starts at the block offset.
      if (evict_take) begin
        inval_v_r     <= 1'b1;
        inval_index_r <= l15.l15_transducer_inval_address_15_4[offset_lp-4 +: index_w_lp];
      end else if (inval_yumi_i) begin
        inval_v_r <= 1'b0;
      end
    end
  end
endmodule

// File: doc/bp_l15_miss_engine.md
# bp_l15_miss_engine

Parametrised miss/store engine between the BlackParrot D-cache and the OpenPiton L1.5. It accepts one outstanding request: cacheable load miss, store, or uncached load. It issues the matching L1.5 transactions, assembles multi-beat fills into a single cache-fill packet, and returns uncached load data. It also forwards L1.5 eviction requests to the D-cache as invalidate packets. It replaces the fixed 512-bit, load/store-only transducer. Block width, associativity and set count are now configurable, and only the expected return type completes a wait state.

## Interface
- paddr_width_p, 40, physical address width
- block_width_p, 512, cache block bits; multiple of 128; beats_lp = block_width_p/128
- sets_p, 64, D-cache sets
- ways_p, 8, D-cache ways; way_id width = clog2(ways_p)
- ptag_width_p, 28, physical tag width
- clk_i  in  1  clock
- reset_n_i  in  1  reset; asynchronous assert, active-low
- ready_o  out  1  engine can accept a request
- req_v_i  in  1  request valid; accepted when req_v_i & ready_o
- req_type_i  in  2  0 load miss, 1 store, 2 uncached load, 3 reserved (dropped)
- req_addr_i  in  paddr_width_p  request address
- req_way_i  in  clog2(ways_p)  victim way
- req_data_i  in  64  store data
- req_size_i  in  2  log2 bytes: 0=1B … 3=8B
- transducer_l15_val / _rqtype[4:0] / _size[2:0] / _address[39:0] / _data[63:0] / _l1rplway[1:0] / _nc  out  L1.5 request
- l15_transducer_ack  in  1  request accepted
- l15_transducer_val / _returntype[3:0] / _data_0[63:0] / _data_1[63:0] / _inval_address_15_4[11:0]  in  L1.5 return
- transducer_l15_req_ack  out  1  return consumed
- fill_v_o / fill_data_o[block_width_p] / fill_index_o / fill_way_o / fill_tag_o[ptag_width_p]  out  fill packet
- fill_yumi_i  in  1  fill consumed
- uc_v_o  out  1  uncached data valid
- uc_data_o  out  64  uncached data
- uc_yumi_i  in  1  uncached data consumed
- inval_v_o  out  1  invalidate packet valid
- inval_index_o  out  clog2(sets_p)  set to invalidate
- inval_yumi_i  in  1  invalidate consumed

## Operation
- States: RESET, READY, SEND, WAIT, FILL, UC_DONE.
- RESET: ack the return only when returntype==INT_RET, then go to READY. All other returns are held un-acked.
- READY: ready_o=1. On accept, capture type/addr/way/data/size and go to SEND. Reserved type: capture nothing, stay in READY.
- SEND drives val=1 and holds all fields stable until ack, then goes to WAIT. Request fields by type:
  - Load miss: LOAD_RQ, size PCX_SZ_16B, address = block-aligned addr + 16*beat, l1rplway = way[1:0].
  - Store: STORE_RQ, size from req_size (1/2/4/8B), data = captured data.
  - Uncached load: LOAD_RQ with nc=1 and size from req_size.
- WAIT completes only on the matching returntype: LOAD_RET for loads, ST_ACK for stores. A non-matching type is not acked here, except EVICT_REQ (see below).
  - Load: push {data_1,data_0} into the SIPO and increment beat. Go to FILL if beat==beats_lp-1, else back to SEND.
  - Store: go to READY.
  - Uncached: latch data_0 and go to UC_DONE.
- FILL: fill_v_o=1 until fill_yumi_i, then clear beat and SIPO and go to READY. Packet fields:
  - index = addr[offset +: clog2(sets_p)], where offset = clog2(block_width_p/8)
  - tag = addr[msb -: ptag_width_p]
  - way = captured way
- UC_DONE: uc_v_o=1 until uc_yumi_i, then go to READY.
- Eviction, any state except RESET: when EVICT_REQ arrives and inval_v_o==0, ack it, set inval_v_o and inval_index_o from inval_address_15_4. inval_v_o holds until inval_yumi_i.
  - If inval_v_o==1, the EVICT_REQ waits un-acked.
  - Eviction has priority over a same-cycle LOAD_RET/ST_ACK. Only one return exists per cycle, so there is no conflict.
- Beat counter is clog2(beats_lp+1) bits and saturates at beats_lp.

## Timing
- Reset: state=RESET. All outputs 0 (ready_o, val, req_ack, fill_v_o, uc_v_o, inval_v_o, all data/address). SIPO and beat are cleared.
- Reset asserted mid-transaction aborts it. After reset the engine must see INT_RET again.
- Accept at cycle t: val=1 at t+1.
- Return ack is combinational in the cycle val & matching type.
- Load latency: beats_lp × (SEND→ack + WAIT→return) + 1 cycle. fill_v_o rises the cycle after the last return is acked.
- ready_o is low from the accept cycle+1 until the cycle after the final yumi/ST_ACK, giving at most 1 outstanding request.
- fill/uc/inval outputs remain stable while valid.

## Structure
- Shared package/header: returntype codes (LOAD_RET, ST_ACK, INT_RET, EVICT_REQ), rqtype codes, PCX_SZ_*, the req_type enum, and the fill/inval packet struct macros.
- Sub-module: bsg_serial_in_parallel_out_full (width 128, els beats_lp) for fill assembly.
- Bypass the SIPO for uncached data.

## Test plan
- Reset, then INT_RET -> ready_o=1 on the next cycle. A LOAD_RET sent before INT_RET -> not acked.
- Load miss at 0x80001040, way 5, block 512 -> four LOAD_RQ to 0x80001040/50/60/70; fill_index=0x01, fill_way=5, data concatenated in beat order.
- Store 4B 0xDEADBEEF at 0x80000008 -> STORE_RQ size 4B. A LOAD_RET during WAIT -> not acked. Then ST_ACK -> READY.
- Uncached 8B load -> nc=1; uc_data_o=data_0; uc_v_o held until uc_yumi_i.
- EVICT_REQ with inval_address_15_4=0x04C during a load WAIT -> acked, inval_index_o=0x13. A second EVICT_REQ before inval_yumi_i -> stalled.
- reset_n_i low after the 2nd beat -> all outputs 0 immediately. Next load re-fetches from beat 0.
